// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position/animation scheduler with double-buffered outputs.
// Define SPRITE_MOTION_BOUNCE_EN for edge bounce; the default build wraps at the screen edges.
module sprite_motion_ctrl #(
    parameter int X_BITS        = 10,
    parameter int Y_BITS        = 10,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int SPRITE_W      = 272,
    parameter int SPRITE_H      = 176,
    parameter int START_X       = 128,
    parameter int START_Y       = 128,
    parameter int ANIM_DIV_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_data,
    output logic [X_BITS-1:0] sprite_x,
    output logic [Y_BITS-1:0] sprite_y,
    output logic              anim_frame,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

    localparam logic signed [X_BITS:0] X_SCREEN = $signed((X_BITS+1)'(SCREEN_W));
    localparam logic signed [Y_BITS:0] Y_SCREEN = $signed((Y_BITS+1)'(SCREEN_H));
    localparam logic signed [X_BITS:0] X_MAX    = $signed((X_BITS+1)'(SCREEN_W - SPRITE_W));
    localparam logic signed [Y_BITS:0] Y_MAX    = $signed((Y_BITS+1)'(SCREEN_H - SPRITE_H));
    localparam logic [X_BITS-1:0]      X_HOME   = X_BITS'(START_X);
    localparam logic [Y_BITS-1:0]      Y_HOME   = Y_BITS'(START_Y);

    state_t                   state, next_state;
    logic [X_BITS-1:0]        wx, step_x_pos;
    logic [Y_BITS-1:0]        wy, step_y_pos;
    logic signed [7:0]        vx, vy, step_vx, step_vy;
    logic [ANIM_DIV_BITS-1:0] anim_cnt;
    logic                     anim_enable, pause;
    logic signed [X_BITS:0]   nx;
    logic signed [Y_BITS:0]   ny;
    logic                     cfg_fire;

    // -128 has no positive counterpart in 8 bits, so it saturates to +127
    function automatic logic signed [7:0] neg_vel(input logic signed [7:0] v);
        return (v == 8'sh80) ? 8'sh7f : -v;
    endfunction

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;

    assign nx = $signed({1'b0, wx}) + $signed({{(X_BITS-7){vx[7]}}, vx});
    assign ny = $signed({1'b0, wy}) + $signed({{(Y_BITS-7){vy[7]}}, vy});

`ifdef SPRITE_MOTION_BOUNCE_EN
    always_comb begin
        step_x_pos = X_BITS'(nx);
        step_vx    = vx;
        if (nx < 0) begin
            step_x_pos = '0;
            step_vx    = neg_vel(vx);
        end else if (nx > X_MAX) begin
            step_x_pos = X_BITS'(X_MAX);
            step_vx    = neg_vel(vx);
        end
    end

    always_comb begin
        step_y_pos = Y_BITS'(ny);
        step_vy    = vy;
        if (ny < 0) begin
            step_y_pos = '0;
            step_vy    = neg_vel(vy);
        end else if (ny > Y_MAX) begin
            step_y_pos = Y_BITS'(Y_MAX);
            step_vy    = neg_vel(vy);
        end
    end
`else
    always_comb begin
        step_x_pos = X_BITS'(nx);
        step_vx    = vx;
        if (nx < 0)
            step_x_pos = X_BITS'(nx + X_SCREEN);
        else if (nx >= X_SCREEN)
            step_x_pos = X_BITS'(nx - X_SCREEN);
    end

    always_comb begin
        step_y_pos = Y_BITS'(ny);
        step_vy    = vy;
        if (ny < 0)
            step_y_pos = Y_BITS'(ny + Y_SCREEN);
        else if (ny >= Y_SCREEN)
            step_y_pos = Y_BITS'(ny - Y_SCREEN);
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_start && !pause) next_state = STEP_X;
            STEP_X:  next_state = STEP_Y;
            STEP_Y:  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Host writes land only in IDLE and steps only outside it, so the two never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wx          <= X_HOME;
            wy          <= Y_HOME;
            sprite_x    <= X_HOME;
            sprite_y    <= Y_HOME;
            vx          <= 8'sd2;
            vy          <= 8'sd1;
            anim_enable <= 1'b1;
            pause       <= 1'b0;
            anim_cnt    <= '0;
            anim_frame  <= 1'b0;
        end else begin
            state <= next_state;
            if (cfg_fire) begin
                case (cfg_addr)
                    2'd0: vx <= cfg_data;
                    2'd1: vy <= cfg_data;
                    2'd2: begin
                        anim_enable <= cfg_data[0];
                        pause       <= cfg_data[2];
                        if (cfg_data[1]) begin
                            wx       <= X_HOME;
                            wy       <= Y_HOME;
                            sprite_x <= X_HOME;
                            sprite_y <= Y_HOME;
                        end
                    end
                    default: ;
                endcase
            end
            case (state)
                STEP_X: begin
                    wx <= step_x_pos;
                    vx <= step_vx;
                end
                STEP_Y: begin
                    wy <= step_y_pos;
                    vy <= step_vy;
                end
                COMMIT: begin
                    sprite_x <= wx;
                    sprite_y <= wy;
                    if (anim_enable) begin
                        anim_cnt <= anim_cnt + 1'b1;
                        if (&anim_cnt) anim_frame <= ~anim_frame;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed self-checking bench for sprite_motion_ctrl; follows SPRITE_MOTION_BOUNCE_EN
// to pick the wrap or bounce edge expectations.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic [9:0] sprite_x, sprite_y;
    logic       anim_frame, busy;

    int checkCount = 0;
    int errorCount = 0;

    sprite_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .anim_frame (anim_frame),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs around a single rising edge, returning at the following negedge
    task automatic applyStimulus(input logic fs, input logic cv, input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        frame_start = fs;
        cfg_valid   = cv;
        cfg_addr    = addr;
        cfg_data    = data;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_valid   = 1'b0;
    endtask

    task automatic runFrame();
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [7:0] data);
        applyStimulus(1'b0, 1'b1, addr, data);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkPos(input string tag, input int ex, input int ey);
        checkOutput({tag, "_x"}, 32'(sprite_x), 32'(ex));
        checkOutput({tag, "_y"}, 32'(sprite_y), 32'(ey));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        #12;
        checkPos("reset", 128, 128);
        checkOutput("reset_anim", 32'(anim_frame), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // First frame: busy for 3 cycles, outputs hold until COMMIT completes
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("frame1_busy%0d", i), 32'(busy), 1);
            checkOutput($sformatf("frame1_hold%0d", i), 32'(sprite_x), 128);
            @(negedge clk);
        end
        checkOutput("frame1_busy_done", 32'(busy), 0);
        checkPos("frame1", 130, 129);
        checkOutput("frame1_anim", 32'(anim_frame), 0);

        // Animation divider: toggles on the 16th commit, frozen once disabled
        doReset();
        for (int i = 0; i < 15; i++) runFrame();
        checkOutput("anim_15", 32'(anim_frame), 0);
        runFrame();
        checkOutput("anim_16", 32'(anim_frame), 1);
        checkPos("anim_16", 160, 144);
        cfgWrite(2'd2, 8'h00);
        for (int i = 0; i < 16; i++) runFrame();
        checkOutput("anim_off", 32'(anim_frame), 1);
        checkPos("anim_off", 192, 160);

        // Write in the frame_start cycle feeds that update; busy blocks writes and frames
        doReset();
        applyStimulus(1'b1, 1'b1, 2'd0, 8'd5);
        checkOutput("same_busy", 32'(busy), 1);
        checkOutput("same_ready", 32'(cfg_ready), 0);
        frame_start = 1'b1;
        cfg_valid   = 1'b1;
        cfg_addr    = 2'd0;
        cfg_data    = 8'd50;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_valid   = 1'b0;
        repeat (2) @(negedge clk);
        checkPos("same", 133, 129);
        checkOutput("same_done", 32'(busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("noqueue_busy", 32'(busy), 0);
        checkOutput("noqueue_x", 32'(sprite_x), 133);
        runFrame();
        checkPos("after_same", 138, 130);

        // Pause: frame_start ignored entirely
        cfgWrite(2'd2, 8'h04);
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        checkOutput("pause_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        checkPos("pause", 138, 130);
        cfgWrite(2'd2, 8'h01);

        // Home: immediate position reset, velocity retained
        cfgWrite(2'd2, 8'h03);
        checkPos("home", 128, 128);
        runFrame();
        checkPos("home_step", 133, 129);

        cfgWrite(2'd2, 8'h03);
`ifdef SPRITE_MOTION_BOUNCE_EN
        cfgWrite(2'd0, 8'd100);
        runFrame(); checkPos("bounce1", 228, 129);
        runFrame(); checkPos("bounce2", 328, 130);
        runFrame(); checkPos("bounce3", 368, 131);
        runFrame(); checkPos("bounce4", 268, 132);
        cfgWrite(2'd1, 8'h80);
        runFrame(); checkPos("bounce5", 168, 4);
        runFrame(); checkPos("bounce6", 68, 0);
        runFrame(); checkPos("bounce7", 0, 127);
        runFrame(); checkPos("bounce8", 100, 254);
`else
        cfgWrite(2'd0, 8'h80);
        runFrame(); checkPos("wrap1", 0, 129);
        runFrame(); checkPos("wrap2", 512, 130);
        cfgWrite(2'd1, 8'h80);
        runFrame(); checkPos("wrap3", 384, 2);
        runFrame(); checkPos("wrap4", 256, 354);
`endif

        // Async reset during STEP_Y: immediate reset values, no partial commit
        applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkPos("midrst", 128, 128);
        checkOutput("midrst_anim", 32'(anim_frame), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        runFrame();
        checkPos("postrst", 130, 129);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
